// File: rtl/down_timer.sv
// Programmable down-counting timer with prescaler, one-shot and auto-reload modes.
// Pulses tc for one cycle at terminal count and reports RUN/DONE on busy/done.
module down_timer #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld,
   input  logic [WIDTH-1:0]      data,
   input  logic                  start,
   input  logic                  en,
   input  logic                  auto,
   input  logic [PRESCALE_W-1:0] presc,
   output logic [WIDTH-1:0]      Q,
   output logic                  tc,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   state_t                state, state_nxt;
   logic [WIDTH-1:0]      rel, rel_nxt;
   logic [WIDTH-1:0]      q_nxt;
   logic [PRESCALE_W-1:0] pcnt, pcnt_nxt;
   logic                  tc_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         Q     <= '0;
         rel   <= '0;
         pcnt  <= '0;
         tc    <= 1'b0;
      end else begin
         state <= state_nxt;
         Q     <= q_nxt;
         rel   <= rel_nxt;
         pcnt  <= pcnt_nxt;
         tc    <= tc_nxt;
      end
   end

   // Priority: ld overrides start, start overrides counting.
   always_comb begin
      state_nxt = state;
      q_nxt     = Q;
      rel_nxt   = rel;
      pcnt_nxt  = pcnt;
      tc_nxt    = 1'b0;
      if (ld) begin
         rel_nxt   = data;
         q_nxt     = data;
         pcnt_nxt  = '0;
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pcnt_nxt  = '0;
                  state_nxt = (Q != ZERO) ? RUN : DONE;
               end
            end
            DONE: begin
               if (start) begin
                  q_nxt     = rel;
                  pcnt_nxt  = '0;
                  state_nxt = (rel != ZERO) ? RUN : DONE;
               end
            end
            RUN: begin
               if (en) begin
                  // >= rather than == so lowering presc mid-run cannot skip a tick.
                  if (pcnt >= presc) begin
                     pcnt_nxt = '0;
                     if (Q > ONE) begin
                        q_nxt = Q - ONE;
                     end else if (Q == ONE) begin
                        tc_nxt = 1'b1;
                        if (auto) begin
                           q_nxt = rel;
                        end else begin
                           q_nxt     = ZERO;
                           state_nxt = DONE;
                        end
                     end else begin
                        state_nxt = DONE;
                     end
                  end else begin
                     pcnt_nxt = pcnt + 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed test-plan steps then random traffic,
// every cycle compared against a behavioural model of the timer rules.
module tb_down_timer;

   localparam int W  = 8;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld, start, en, auto;
   logic [W-1:0]  data;
   logic [PW-1:0] presc;
   logic [W-1:0]  Q;
   logic          tc, busy, done;

   int vectors     = 0;
   int miscompares = 0;

   // model state: mode 0=idle, 1=running, 2=finished
   int m_q, m_rel, m_pcnt, m_mode;
   bit m_tc;

   logic [W+2:0] exp_q[$];

   down_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
      .clk(clk), .rst(rst), .ld(ld), .data(data), .start(start), .en(en),
      .auto(auto), .presc(presc), .Q(Q), .tc(tc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [W+2:0] model_word();
      return {m_tc, (m_mode == 1), (m_mode == 2), W'(m_q)};
   endfunction

   task automatic model_reset();
      m_q = 0; m_rel = 0; m_pcnt = 0; m_mode = 0; m_tc = 0;
      exp_q.push_back(model_word());
   endtask

   // One clock edge of the timer, written from the behavioural rules.
   task automatic model_edge();
      m_tc = 0;
      if (ld) begin
         m_rel = int'(data); m_q = int'(data); m_pcnt = 0; m_mode = 0;
      end else if (m_mode == 0 && start) begin
         m_pcnt = 0;
         m_mode = (m_q == 0) ? 2 : 1;
      end else if (m_mode == 2 && start) begin
         m_q = m_rel; m_pcnt = 0;
         m_mode = (m_rel == 0) ? 2 : 1;
      end else if (m_mode == 1 && en) begin
         if (m_pcnt >= int'(presc)) begin
            m_pcnt = 0;
            if (m_q > 1) m_q = m_q - 1;
            else begin
               m_tc = 1;
               if (auto) m_q = m_rel;
               else begin m_q = 0; m_mode = 2; end
            end
         end else m_pcnt = m_pcnt + 1;
      end
      exp_q.push_back(model_word());
   endtask

   task automatic check(input string tag);
      logic [W+2:0] exp_w, obs_w;
      obs_w = {tc, busy, done, Q};
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $error("FAIL %s scoreboard empty obs=%h", tag, obs_w);
      end else begin
         exp_w = exp_q.pop_front();
         assert (obs_w === exp_w) else begin
            miscompares++;
            $error("FAIL %s obs{tc,busy,done,Q}=%h exp=%h", tag, obs_w, exp_w);
         end
      end
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check(tag);
   endtask

   task automatic load(input logic [W-1:0] d);
      ld = 1'b1; data = d; start = 1'b0;
      cycle("load");
      ld = 1'b0;
   endtask

   task automatic kick(input string tag);
      start = 1'b1;
      cycle(tag);
      start = 1'b0;
   endtask

   task automatic run_until(input int v, input string tag);
      bit found = 0;
      for (int i = 0; i < 64; i++) begin
         if (m_q == v && m_mode == 1) begin found = 1; break; end
         cycle(tag);
      end
      vectors++;
      assert (found) else begin
         miscompares++;
         $error("FAIL %s_wait never reached Q=%0d obs=%0d", tag, v, Q);
      end
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      model_reset();
      #1 check(tag);
      #2 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ld = 0; start = 0; en = 0; auto = 0; data = '0; presc = '0;
      model_reset();
      #3 check("reset");
      @(negedge clk) rst = 1'b0;

      // 1: one-shot, presc=0
      presc = 0; auto = 0; en = 1;
      load(8'd5);
      kick("t1_start");
      repeat (8) cycle("t1_run");

      // 2: prescaled one-shot
      presc = 3;
      load(8'd2);
      kick("t2_start");
      repeat (12) cycle("t2_run");

      // 3: auto-reload, then clear auto
      presc = 0; auto = 1;
      load(8'd3);
      kick("t3_start");
      repeat (9) cycle("t3_auto");
      run_until(2, "t3");
      auto = 0;
      repeat (5) cycle("t3_stop");

      // 4: pause mid-run, then restart from DONE
      load(8'd6);
      kick("t4_start");
      run_until(4, "t4");
      en = 0;
      repeat (5) cycle("t4_pause");
      en = 1;
      repeat (8) cycle("t4_resume");
      kick("t4_restart");
      repeat (2) cycle("t4_rerun");

      // 5: ld beats start; zero load goes straight to DONE
      load(8'd9);
      kick("t5_start");
      run_until(7, "t5");
      ld = 1; start = 1; data = 8'h20;
      cycle("t5_ldstart");
      ld = 0; start = 0;
      repeat (2) cycle("t5_idle");
      load(8'd0);
      kick("t5_zero");
      repeat (3) cycle("t5_done");

      // 6: asynchronous reset mid-run
      load(8'd12);
      kick("t6_start");
      run_until(9, "t6");
      async_reset("t6_async_rst");
      repeat (3) cycle("t6_after");

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         ld    = ($urandom_range(0, 15) == 0);
         data  = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
         start = ($urandom_range(0, 7) == 0);
         en    = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 9) == 0) auto = $urandom_range(0, 1);
         if ($urandom_range(0, 19) == 0) presc = PW'($urandom_range(0, 3));
         if ($urandom_range(0, 299) == 0) async_reset("rnd_async_rst");
         else cycle("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
